// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: handshake FSM state
// encodings, default FIFO depth and the busy-acknowledge timeout.
package uart_tx_fifo_pkg;

    // Default log2 of FIFO depth (16 entries).
    localparam int UART_FIFO_DEPTH_LOG2_DEFAULT = 4;

    // Cycles spent in WAIT_BUSY without seeing tx_busy before the latch is
    // treated as dropped by the transmitter.
    localparam int UART_TX_BUSY_TIMEOUT = 3;

    typedef enum logic [1:0] {
        UART_TX_ST_IDLE      = 2'd0,
        UART_TX_ST_WAIT_BUSY = 2'd1,
        UART_TX_ST_WAIT_DONE = 2'd2
    } uart_tx_state_e;

    // Counts cycles spent waiting for tx_busy to rise.
    typedef logic [1:0] busy_cnt_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side push/status signals and transmitter handshake of the UART
// transmit FIFO. The slave modport is the FIFO; master is its environment.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
);
    logic [7:0]          wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] level;
    logic [7:0]          tx_data;
    logic                tx_latch;
    logic                tx_busy;
    logic                ovf;
    logic                ovf_clr;

    modport slave (
        input  wr_data, wr_en, tx_busy, ovf_clr,
        output full, empty, level, tx_data, tx_latch, ovf
    );

    modport master (
        output wr_data, wr_en, tx_busy, ovf_clr,
        input  full, empty, level, tx_data, tx_latch, ovf
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Byte-wide circular-buffer FIFO with registered full/empty/level.
// Push is ignored while full, pop while empty; dout always shows the
// entry at the read pointer. Shared by the UART TX and RX paths.
module uart_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                push,
    input  logic                pop,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DEPTH_LOG2:0]   level_next;

    // Qualify requests against the registered flags and derive the next occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        level_next = level;
        if (push_ok && !pop_ok) begin
            level_next = level + LEVEL_ONE;
        end else if (pop_ok && !push_ok) begin
            level_next = level - LEVEL_ONE;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; unwritten entries are never read, and an unreset array can map onto RAM.
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and status flags, all updated on the edge that moves them.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_next;
            full  <= (level_next == LEVEL_FULL);
            empty <= (level_next == '0);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side FIFO in front of the UART transmitter. Buffers bus byte
// writes and hands them to the transmitter one at a time through the
// tx_latch/tx_busy handshake.
// Optional feature: define UART_TX_FIFO_OVF_EN for a sticky overflow flag
// (ovf, cleared by ovf_clr); otherwise ovf is constant 0.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
) (
    input  logic           clk,
    input  logic           nrst,
    uart_tx_fifo_if.slave  bus
);
    localparam busy_cnt_t BUSY_LAST = busy_cnt_t'(UART_TX_BUSY_TIMEOUT - 1);
    localparam busy_cnt_t BUSY_ONE  = busy_cnt_t'(1);

    uart_tx_state_e state;
    busy_cnt_t      busy_cnt;
    logic [7:0]     tx_data_q;
    logic           tx_latch_q;
    logic [7:0]     mem_dout;
    logic           pop;

    // A byte leaves the FIFO only when the FSM is idle and the transmitter is free.
    assign pop = (state == UART_TX_ST_IDLE) && !bus.empty && !bus.tx_busy;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .nrst  (nrst),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (mem_dout),
        .full  (bus.full),
        .empty (bus.empty),
        .level (bus.level)
    );

    // Handshake FSM: pop into tx_data with a one-cycle latch, then follow the busy window.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= UART_TX_ST_IDLE;
            busy_cnt   <= '0;
            tx_data_q  <= '0;
            tx_latch_q <= 1'b0;
        end else begin
            tx_latch_q <= 1'b0;
            unique case (state)
                UART_TX_ST_IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_dout;
                        tx_latch_q <= 1'b1;
                        busy_cnt   <= '0;
                        state      <= UART_TX_ST_WAIT_BUSY;
                    end
                end
                UART_TX_ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= UART_TX_ST_WAIT_DONE;
                    end else if (busy_cnt == BUSY_LAST) begin
                        // Transmitter never acknowledged; treat the byte as sent.
                        state <= UART_TX_ST_IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + BUSY_ONE;
                    end
                end
                UART_TX_ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= UART_TX_ST_IDLE;
                    end
                end
                default: begin
                    state <= UART_TX_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_latch = tx_latch_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    // Sticky overflow: a push dropped against the registered full sets it; set beats clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_en && bus.full) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: a 16-entry instance (A) and a
// 4-entry instance (B), each with a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    import uart_tx_fifo_pkg::*;

    localparam int LEN_A    = 12;
    localparam int LEN_B    = 4;
    localparam int PERIOD_B = LEN_B + 3;
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_tx_fifo_if #(.DEPTH_LOG2(4)) ifa ();
    uart_tx_fifo_if #(.DEPTH_LOG2(2)) ifb ();

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut_a (.clk(clk), .nrst(nrst), .bus(ifa.slave));
    uart_tx_fifo #(.DEPTH_LOG2(2)) dut_b (.clk(clk), .nrst(nrst), .bus(ifb.slave));

    always #31.25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model A: accepts a latch when idle and stays busy LEN_A cycles.
    logic busy_force_a = 1'b0;
    logic model_busy_a = 1'b0;
    int   cnt_a        = 0;
    int   ignore_req   = 0;
    int   ignore_done  = 0;
    assign ifa.tx_busy = model_busy_a | busy_force_a;

    always @(posedge clk) begin
        if (cnt_a != 0) begin
            cnt_a        <= cnt_a - 1;
            model_busy_a <= (cnt_a != 1);
        end else if (ifa.tx_latch && !ifa.tx_busy) begin
            if (ignore_req != ignore_done) begin
                ignore_done <= ignore_done + 1;
            end else begin
                cnt_a        <= LEN_A;
                model_busy_a <= 1'b1;
            end
        end
    end

    // Transmitter model B.
    logic busy_force_b = 1'b0;
    logic model_busy_b = 1'b0;
    int   cnt_b        = 0;
    assign ifb.tx_busy = model_busy_b | busy_force_b;

    always @(posedge clk) begin
        if (cnt_b != 0) begin
            cnt_b        <= cnt_b - 1;
            model_busy_b <= (cnt_b != 1);
        end else if (ifb.tx_latch && !ifb.tx_busy) begin
            cnt_b        <= LEN_B;
            model_busy_b <= 1'b1;
        end
    end

    // Monitors: record latched bytes, latch cycles and busy falls.
    logic [7:0] got_a[$];
    int         lat_cyc_a[$];
    int         fall_cyc_a[$];
    int         bad_pulse_a = 0;
    int         bad_busy_a  = 0;
    logic       prev_latch_a = 1'b0;
    logic       prev_busy_a  = 1'b0;
    logic [7:0] got_b[$];

    always @(negedge clk) begin
        if (ifa.tx_latch) begin
            got_a.push_back(ifa.tx_data);
            lat_cyc_a.push_back(cyc);
            if (prev_latch_a) bad_pulse_a++;
            if (ifa.tx_busy) bad_busy_a++;
        end
        if (prev_busy_a && !ifa.tx_busy) fall_cyc_a.push_back(cyc);
        prev_latch_a = ifa.tx_latch;
        prev_busy_a  = ifa.tx_busy;
        if (ifb.tx_latch) got_b.push_back(ifb.tx_data);
    end

    task automatic push_a(input logic [7:0] d);
        @(negedge clk);
        ifa.wr_en   = 1'b1;
        ifa.wr_data = d;
        @(negedge clk);
        ifa.wr_en   = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        @(negedge clk);
        ifb.wr_en   = 1'b1;
        ifb.wr_data = d;
        @(negedge clk);
        ifb.wr_en   = 1'b0;
    endtask

    task automatic wait_got_a(input int n, input int budget);
        for (int i = 0; i < budget && got_a.size() < n; i++) @(negedge clk);
    endtask

    task automatic settle_a();
        for (int i = 0; i < 100 && ifa.tx_busy; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ifa.level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", ifa.level); end
        checks++; if (ifa.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", ifa.empty); end
        checks++; if (ifa.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", ifa.full); end
        checks++; if (ifa.tx_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b expected 0", ifa.tx_latch); end
        checks++; if (ifa.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", ifa.tx_data); end
        checks++; if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ifa.ovf); end
        nrst = 1'b1;
        busy_force_a = 1'b1;
        for (int i = 0; i < 5; i++) push_a(8'hA0 + 8'(i));
        checks++; if (ifa.level !== 5'd5) begin errors++; $display("FAIL burst_queued_level: got %0d expected 5", ifa.level); end
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checks++; if (ifa.level !== 5'd0) begin errors++; $display("FAIL midreset_level: got %0d expected 0", ifa.level); end
        checks++; if (ifa.empty !== 1'b1) begin errors++; $display("FAIL midreset_empty: got %b expected 1", ifa.empty); end
        checks++; if (ifa.tx_latch !== 1'b0) begin errors++; $display("FAIL midreset_latch: got %b expected 0", ifa.tx_latch); end
        busy_force_a = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (got_a.size() !== 0) begin errors++; $display("FAIL midreset_no_latch: got %0d latches expected 0", got_a.size()); end
    endtask

    task automatic test_single_byte();
        int base;
        int k;
        base = got_a.size();
        @(negedge clk);
        ifa.wr_en   = 1'b1;
        ifa.wr_data = 8'h41;
        @(negedge clk);
        ifa.wr_en = 1'b0;
        k = cyc;
        checks++; if (ifa.empty !== 1'b0) begin errors++; $display("FAIL single_empty_fall: got %b expected 0", ifa.empty); end
        checks++; if (ifa.level !== 5'd1) begin errors++; $display("FAIL single_level_push: got %0d expected 1", ifa.level); end
        checks++; if (ifa.tx_latch !== 1'b0) begin errors++; $display("FAIL single_latch_early: got %b expected 0", ifa.tx_latch); end
        @(negedge clk);
        checks++; if (ifa.tx_latch !== 1'b1) begin errors++; $display("FAIL single_latch_k1: got %b expected 1", ifa.tx_latch); end
        checks++; if (ifa.tx_data !== 8'h41) begin errors++; $display("FAIL single_tx_data: got %h expected 41", ifa.tx_data); end
        checks++; if (ifa.level !== 5'd0) begin errors++; $display("FAIL single_level_pop: got %0d expected 0", ifa.level); end
        @(negedge clk);
        checks++; if (ifa.tx_latch !== 1'b0) begin errors++; $display("FAIL single_latch_width: got %b expected 0", ifa.tx_latch); end
        settle_a();
        checks++; if (got_a.size() !== base + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_a.size(), base + 1); end
        else begin
            checks++; if (lat_cyc_a[base] !== k + 1) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", lat_cyc_a[base], k + 1); end
        end
        checks++; if (ifa.tx_data !== 8'h41) begin errors++; $display("FAIL single_tx_data_hold: got %h expected 41", ifa.tx_data); end
    endtask

    task automatic test_burst();
        int base;
        int fall;
        base = got_a.size();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            ifa.wr_en   = 1'b1;
            ifa.wr_data = 8'(i);
        end
        @(negedge clk);
        ifa.wr_en = 1'b0;
        wait_got_a(base + 5, 300);
        checks++;
        if (got_a.size() !== base + 5) begin
            errors++; $display("FAIL burst_count: got %0d expected %0d", got_a.size(), base + 5);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (got_a[base + i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", i, got_a[base + i], 8'(i + 1)); end
            end
            for (int i = 1; i < 5; i++) begin
                fall = -1000;
                foreach (fall_cyc_a[j]) if (fall_cyc_a[j] < lat_cyc_a[base + i]) fall = fall_cyc_a[j];
                checks++; if (lat_cyc_a[base + i] - fall !== 2) begin errors++; $display("FAIL burst_gap%0d: got %0d edges expected 2", i, lat_cyc_a[base + i] - fall); end
            end
        end
        settle_a();
        checks++; if (bad_busy_a !== 0) begin errors++; $display("FAIL latch_while_busy: got %0d expected 0", bad_busy_a); end
        checks++; if (bad_pulse_a !== 0) begin errors++; $display("FAIL latch_pulse_width: got %0d long pulses expected 0", bad_pulse_a); end
    endtask

    task automatic test_overflow();
        int base;
        base = got_a.size();
        busy_force_a = 1'b1;
        for (int i = 0; i < 15; i++) push_a(8'h80 + 8'(i));
        checks++; if (ifa.full !== 1'b0) begin errors++; $display("FAIL ovf_full_at15: got %b expected 0", ifa.full); end
        push_a(8'h8F);
        checks++; if (ifa.full !== 1'b1) begin errors++; $display("FAIL ovf_full_at16: got %b expected 1", ifa.full); end
        checks++; if (ifa.level !== 5'd16) begin errors++; $display("FAIL ovf_level16: got %0d expected 16", ifa.level); end
        checks++; if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ifa.ovf); end
        push_a(8'hEE);
        checks++; if (ifa.level !== 5'd16) begin errors++; $display("FAIL ovf_level_drop: got %0d expected 16", ifa.level); end
        checks++; if (ifa.ovf !== OVF_ON) begin errors++; $display("FAIL ovf_set: got %b expected %b", ifa.ovf, OVF_ON); end
        @(negedge clk); ifa.ovf_clr = 1'b1;
        @(negedge clk); ifa.ovf_clr = 1'b0;
        checks++; if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ifa.ovf); end
        @(negedge clk); ifa.ovf_clr = 1'b1; ifa.wr_en = 1'b1; ifa.wr_data = 8'hEF;
        @(negedge clk); ifa.ovf_clr = 1'b0; ifa.wr_en = 1'b0;
        checks++; if (ifa.ovf !== OVF_ON) begin errors++; $display("FAIL ovf_set_wins: got %b expected %b", ifa.ovf, OVF_ON); end
        @(negedge clk); ifa.ovf_clr = 1'b1;
        @(negedge clk); ifa.ovf_clr = 1'b0;
        busy_force_a = 1'b0;
        wait_got_a(base + 16, 800);
        checks++;
        if (got_a.size() !== base + 16) begin
            errors++; $display("FAIL ovf_drain_count: got %0d expected %0d", got_a.size(), base + 16);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (got_a[base + i] !== 8'h80 + 8'(i)) begin errors++; $display("FAIL ovf_drain_byte%0d: got %h expected %h", i, got_a[base + i], 8'h80 + 8'(i)); end
            end
        end
        settle_a();
        checks++; if (ifa.empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty: got %b expected 1", ifa.empty); end
    endtask

    task automatic test_wrap();
        int base;
        int e;
        base = got_b.size();
        busy_force_b = 1'b1;
        push_b(8'h10);
        push_b(8'h11);
        checks++; if (ifb.level !== 3'd2) begin errors++; $display("FAIL wrap_prefill_level: got %0d expected 2", ifb.level); end
        @(negedge clk);
        busy_force_b = 1'b0;
        @(negedge clk);
        e = cyc;
        checks++; if (ifb.tx_latch !== 1'b1) begin errors++; $display("FAIL wrap_first_latch: got %b expected 1", ifb.tx_latch); end
        for (int n = 1; n <= 8; n++) begin
            for (int i = 0; i < 50 && cyc < e + n * PERIOD_B - 1; i++) @(negedge clk);
            checks++; if (ifb.level !== 3'd1) begin errors++; $display("FAIL wrap_level_before%0d: got %0d expected 1", n, ifb.level); end
            ifb.wr_en   = 1'b1;
            ifb.wr_data = 8'h11 + 8'(n);
            @(negedge clk);
            ifb.wr_en = 1'b0;
            checks++; if (ifb.tx_latch !== 1'b1) begin errors++; $display("FAIL wrap_pop_same_cycle%0d: got %b expected 1", n, ifb.tx_latch); end
            checks++; if (ifb.level !== 3'd1) begin errors++; $display("FAIL wrap_level_after%0d: got %0d expected 1", n, ifb.level); end
        end
        for (int i = 0; i < 60 && got_b.size() < base + 10; i++) @(negedge clk);
        checks++;
        if (got_b.size() !== base + 10) begin
            errors++; $display("FAIL wrap_count: got %0d expected %0d", got_b.size(), base + 10);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (got_b[base + i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, got_b[base + i], 8'h10 + 8'(i)); end
            end
        end
        repeat (2) @(negedge clk);
        checks++; if (ifb.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", ifb.empty); end
    endtask

    task automatic test_missed_busy();
        int base;
        base = got_a.size();
        busy_force_a = 1'b1;
        push_a(8'h55);
        push_a(8'h66);
        ignore_req = ignore_req + 1;
        @(negedge clk);
        busy_force_a = 1'b0;
        wait_got_a(base + 2, 40);
        checks++;
        if (got_a.size() !== base + 2) begin
            errors++; $display("FAIL missed_count: got %0d expected %0d", got_a.size(), base + 2);
        end else begin
            checks++; if (got_a[base] !== 8'h55) begin errors++; $display("FAIL missed_byte0: got %h expected 55", got_a[base]); end
            checks++; if (got_a[base + 1] !== 8'h66) begin errors++; $display("FAIL missed_byte1: got %h expected 66", got_a[base + 1]); end
            checks++; if (lat_cyc_a[base + 1] - lat_cyc_a[base] !== 4) begin errors++; $display("FAIL missed_timeout: got %0d edges expected 4", lat_cyc_a[base + 1] - lat_cyc_a[base]); end
        end
        repeat (3) @(negedge clk);
        checks++; if (ifa.tx_busy !== 1'b1) begin errors++; $display("FAIL missed_second_accepted: got busy %b expected 1", ifa.tx_busy); end
        settle_a();
        checks++; if (ignore_done !== ignore_req) begin errors++; $display("FAIL missed_ignored: got %0d expected %0d", ignore_done, ignore_req); end
        checks++; if (ifa.tx_data !== 8'h66) begin errors++; $display("FAIL missed_tx_data: got %h expected 66", ifa.tx_data); end
        checks++; if (bad_busy_a !== 0) begin errors++; $display("FAIL missed_latch_while_busy: got %0d expected 0", bad_busy_a); end
    endtask

    initial begin
        ifa.wr_en = 1'b0; ifa.wr_data = 8'h00; ifa.ovf_clr = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_data = 8'h00; ifb.ovf_clr = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_wrap();
        test_missed_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
